// File: rtl/frame_sequencer.sv
// Frame sequencer: turns host LOAD/PROC/READ/CLEAR commands into control for the
// address FSM and tracks bank rotation. Optional watchdog: define FRAME_SEQUENCER_TIMEOUT_EN.
module frame_sequencer #(
    parameter int NB_IMAGE    = 10,
    parameter int NB_CMD      = 3,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              i_CLK,
    input  logic              i_reset,
    input  logic [NB_CMD-1:0] i_cmd,
    input  logic              i_cmdVld,
    input  logic              i_changeBlock,
    input  logic              i_EoP,
    output logic              o_load,
    output logic              o_SoP,
    output logic [1:0]        o_wrBank,
    output logic [1:0]        o_rdBase,
    output logic [1:0]        o_fill,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_timeout
);

    typedef enum logic [2:0] {IDLE, LOAD, PROC, DRAIN, READ} state_t;

    state_t     state, state_next;
    logic       cb_q;
    logic       cb_event;
    logic       cmd_clear, cmd_other;
    logic [1:0] wr_bank_next, fill_next;
    logic       done_next, err_next;
    logic       tmo_hit;
    logic       unused_cfg;

    assign unused_cfg = (NB_IMAGE == 0) || (TIMEOUT_CYC == 0);
    assign cb_event   = i_changeBlock && !cb_q;
    assign cmd_clear  = i_cmdVld && (i_cmd == NB_CMD'(4));
    assign cmd_other  = i_cmdVld && !cmd_clear;

    always_comb begin
        state_next   = state;
        wr_bank_next = o_wrBank;
        fill_next    = o_fill;
        done_next    = 1'b0;
        err_next     = 1'b0;
        if (cmd_clear) begin
            state_next   = IDLE;
            wr_bank_next = 2'd0;
            fill_next    = 2'd0;
        end else if (tmo_hit) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end else if (state == IDLE) begin
            if (cmd_other) begin
                if (i_cmd == NB_CMD'(1)) begin
                    state_next = LOAD;
                end else if (i_cmd == NB_CMD'(2) && o_fill == 2'd3) begin
                    state_next = PROC;
                end else begin
                    err_next = 1'b1;
                end
            end
        end else begin
            // Outside IDLE every non-CLEAR command is rejected; block events still advance the FSM
            err_next = cmd_other;
            case (state)
                LOAD: begin
                    if (cb_event) begin
                        state_next   = IDLE;
                        wr_bank_next = o_wrBank + 2'd1;
                        fill_next    = (o_fill == 2'd3) ? 2'd3 : o_fill + 2'd1;
                        done_next    = 1'b1;
                    end
                end
                PROC: begin
                    if (cb_event) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_EoP) begin
                        state_next = READ;
                    end
                end
                READ: begin
                    if (cb_event && !i_EoP) begin
                        state_next = IDLE;
                        fill_next  = 2'd2;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state    <= IDLE;
            cb_q     <= 1'b0;
            o_load   <= 1'b0;
            o_SoP    <= 1'b0;
            o_wrBank <= 2'd0;
            o_rdBase <= 2'd0;
            o_fill   <= 2'd0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_next;
            cb_q     <= i_changeBlock;
            o_load   <= (state_next == LOAD);
            o_SoP    <= (state_next == PROC);
            o_wrBank <= wr_bank_next;
            o_rdBase <= wr_bank_next + 2'd1;
            o_fill   <= fill_next;
            o_busy   <= (state_next != IDLE);
            o_done   <= done_next;
            o_err    <= err_next;
        end
    end

`ifdef FRAME_SEQUENCER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] tmo_cnt;
    logic          timeout_next;

    // Counts cycles already spent in the current non-IDLE state; fires on the last one
    assign tmo_hit = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        timeout_next = o_timeout;
        if (cmd_clear) begin
            timeout_next = 1'b0;
        end else if (tmo_hit) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset || state == IDLE || state_next != state) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_next;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed, table-driven bench for frame_sequencer; expectations are hand-computed constants.
// Output vectors are packed as {load, sop, wrBank, rdBase, fill, busy, done, err, timeout}.
module tb_frame_sequencer;

    localparam int TMO = 16;
`ifdef FRAME_SEQUENCER_TIMEOUT_EN
    localparam int LOAD_GAP = 12;
`else
    localparam int LOAD_GAP = 20;
`endif

    logic       i_CLK = 1'b0;
    logic       i_reset = 1'b0;
    logic [2:0] i_cmd = 3'd0;
    logic       i_cmdVld = 1'b0;
    logic       i_changeBlock = 1'b0;
    logic       i_EoP = 1'b0;
    logic       o_load, o_SoP, o_busy, o_done, o_err, o_timeout;
    logic [1:0] o_wrBank, o_rdBase, o_fill;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  cmd;
        logic        cb;
        logic        eop;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    frame_sequencer #(
        .NB_IMAGE   (10),
        .NB_CMD     (3),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .i_CLK        (i_CLK),
        .i_reset      (i_reset),
        .i_cmd        (i_cmd),
        .i_cmdVld     (i_cmdVld),
        .i_changeBlock(i_changeBlock),
        .i_EoP        (i_EoP),
        .o_load       (o_load),
        .o_SoP        (o_SoP),
        .o_wrBank     (o_wrBank),
        .o_rdBase     (o_rdBase),
        .o_fill       (o_fill),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_timeout    (o_timeout)
    );

    always #5 i_CLK = ~i_CLK;

    function automatic logic [11:0] pk(input logic ld, input logic sp, input logic [1:0] wr,
                                       input logic [1:0] rd, input logic [1:0] fl, input logic bz,
                                       input logic dn, input logic er, input logic tm);
        return {ld, sp, wr, rd, fl, bz, dn, er, tm};
    endfunction

    function automatic vec_t mk(input logic rst, input logic vld, input logic [2:0] cmd,
                                input logic cb, input logic eop, input logic [11:0] exp);
        vec_t v;
        v.rst = rst;
        v.vld = vld;
        v.cmd = cmd;
        v.cb  = cb;
        v.eop = eop;
        v.exp = exp;
        return v;
    endfunction

    // Drive one cycle of inputs, then let the rising edge pass before sampling
    task automatic applyStimulus(input logic rst, input logic vld, input logic [2:0] cmd,
                                 input logic cb, input logic eop);
        i_reset       = rst;
        i_cmdVld      = vld;
        i_cmd         = cmd;
        i_changeBlock = cb;
        i_EoP         = eop;
        @(posedge i_CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {o_load, o_SoP, o_wrBank, o_rdBase, o_fill, o_busy, o_done, o_err, o_timeout};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic doLoad();
        applyStimulus(0, 1, 3'd1, 0, 0);
        applyStimulus(0, 0, 3'd0, 1, 0);
        applyStimulus(0, 0, 3'd0, 0, 0);
    endtask

    initial begin
        // Process, drain/read, wrap and saturate, error cases, CLEAR, coincidences, reset
        vecs.push_back(mk(0, 1, 3'd2, 0, 0, pk(0, 1, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(0, 1, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(0, 0, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 1, pk(0, 0, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(0, 0, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 3, 0, 2, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(0, 0, 3, 0, 2, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 0, 0, pk(1, 0, 3, 0, 2, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 0, 1, 3, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 0, 0, pk(1, 0, 0, 1, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 1, 2, 3, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd4, 0, 0, pk(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 0, 0, pk(1, 0, 0, 1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 1, 2, 1, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd2, 0, 0, pk(0, 0, 1, 2, 1, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(0, 0, 1, 2, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd3, 0, 0, pk(0, 0, 1, 2, 1, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 1, 3'd0, 0, 0, pk(0, 0, 1, 2, 1, 0, 0, 1, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 0, 0, pk(1, 0, 1, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd2, 0, 0, pk(1, 0, 1, 2, 1, 1, 0, 1, 0)));
        vecs.push_back(mk(0, 1, 3'd7, 0, 0, pk(1, 0, 1, 2, 1, 1, 0, 1, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(1, 0, 1, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd4, 0, 0, pk(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 0, 0, pk(1, 0, 0, 1, 0, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 1, 2, 1, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 0, 0, pk(1, 0, 1, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd2, 1, 0, pk(0, 0, 2, 3, 2, 0, 1, 1, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 0, 0, pk(1, 0, 2, 3, 2, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 1, 0, pk(0, 0, 3, 0, 3, 0, 1, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd2, 0, 0, pk(0, 1, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 1, 3'd1, 1, 0, pk(0, 0, 3, 0, 3, 1, 0, 1, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 1, pk(0, 0, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(0, 0, 3, 0, 3, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 3'd4, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 3'd0, 0, 0, pk(0, 0, 0, 1, 0, 0, 0, 0, 0)));

        applyStimulus(1, 0, 3'd0, 0, 0);
        checkOutput("reset_state", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Three slow loads: each block finishes LOAD_GAP cycles after the command
        for (int b = 0; b < 3; b++) begin
            applyStimulus(0, 1, 3'd1, 0, 0);
            checkOutput($sformatf("load%0d_start", b),
                        pk(1, 0, 2'(b), 2'(b + 1), 2'(b), 1, 0, 0, 0));
            repeat (LOAD_GAP - 1) applyStimulus(0, 0, 3'd0, 0, 0);
            checkOutput($sformatf("load%0d_hold", b),
                        pk(1, 0, 2'(b), 2'(b + 1), 2'(b), 1, 0, 0, 0));
            applyStimulus(0, 0, 3'd0, 1, 0);
            checkOutput($sformatf("load%0d_done", b),
                        pk(0, 0, 2'(b + 1), 2'(b + 2), 2'(b + 1), 0, 1, 0, 0));
            applyStimulus(0, 0, 3'd0, 0, 0);
            checkOutput($sformatf("load%0d_idle", b),
                        pk(0, 0, 2'(b + 1), 2'(b + 2), 2'(b + 1), 0, 0, 0, 0));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].cmd, vecs[i].cb, vecs[i].eop);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Long PROC with no block-finished event: watchdog behaviour
        doLoad();
        doLoad();
        doLoad();
        checkOutput("prefill_three", pk(0, 0, 3, 0, 3, 0, 0, 0, 0));
        applyStimulus(0, 1, 3'd2, 0, 0);
        checkOutput("long_proc_start", pk(0, 1, 3, 0, 3, 1, 0, 0, 0));
`ifdef FRAME_SEQUENCER_TIMEOUT_EN
        repeat (TMO - 1) applyStimulus(0, 0, 3'd0, 0, 0);
        checkOutput("before_timeout", pk(0, 1, 3, 0, 3, 1, 0, 0, 0));
        applyStimulus(0, 0, 3'd0, 0, 0);
        checkOutput("timeout_fire", pk(0, 0, 3, 0, 3, 0, 0, 1, 1));
        repeat (3) applyStimulus(0, 0, 3'd0, 0, 0);
        checkOutput("timeout_sticky", pk(0, 0, 3, 0, 3, 0, 0, 0, 1));
        applyStimulus(0, 1, 3'd4, 0, 0);
        checkOutput("timeout_clear", pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
`else
        repeat (100) applyStimulus(0, 0, 3'd0, 0, 0);
        checkOutput("proc_waits", pk(0, 1, 3, 0, 3, 1, 0, 0, 0));
        applyStimulus(0, 1, 3'd4, 0, 0);
        checkOutput("proc_clear", pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The block SHALL have parameter NB_IMAGE, default 10, width of image length.
REQ-002 The block SHALL have parameter NB_CMD, default 3, width of host command.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, watchdog limit in cycles.
REQ-004 The block SHALL have port i_CLK  in  1  single clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port i_cmd  in  NB_CMD  host command: 1=LOAD, 2=PROC, 3=READ, 4=CLEAR, others illegal.
REQ-007 The block SHALL have port i_cmdVld  in  1  one-cycle strobe qualifying i_cmd.
REQ-008 The block SHALL have port i_changeBlock  in  1  level from address FSM; block finished.
REQ-009 The block SHALL have port i_EoP  in  1  address FSM end-of-process flag.
REQ-010 The block SHALL have ports o_load and o_SoP  out  1 each  drive address FSM load / start-of-process.
REQ-011 The block SHALL have port o_wrBank  out  2  bank (0..3) receiving load data.
REQ-012 The block SHALL have port o_rdBase  out  2  oldest of three banks feeding the convolver, equal to o_wrBank+1 mod 4.
REQ-013 The block SHALL have port o_fill  out  2  loaded-row count, 0..3.
REQ-014 The block SHALL have ports o_busy (level), o_done (pulse), o_err (pulse) and o_timeout (sticky), each out 1.

Function
REQ-015 States SHALL be IDLE, LOAD, PROC, DRAIN and READ; all outputs SHALL be registered.
REQ-016 A change-block event SHALL be a rising edge of i_changeBlock, detected against its value registered one cycle earlier.
REQ-017 In IDLE, LOAD accepted at edge k SHALL move to LOAD with o_load=1 from cycle k+1.
REQ-018 In LOAD, on a change-block event: go to IDLE, o_load=0, o_wrBank+=1 mod 4, o_fill=min(o_fill+1,3), 1-cycle o_done.
REQ-019 In IDLE, PROC with o_fill==3 SHALL move to PROC with o_SoP=1 next cycle; with o_fill<3 it SHALL pulse o_err and stay IDLE.
REQ-020 In PROC, on a change-block event: o_SoP=0, go to DRAIN.
REQ-021 In DRAIN: with i_EoP==1 go to READ; otherwise remain.
REQ-022 READ SHALL be entered from DRAIN only; in IDLE a READ command SHALL pulse o_err and be ignored.
REQ-023 In READ, on a change-block event while i_EoP==0: go to IDLE, o_fill=2 (oldest row retired), 1-cycle o_done.
REQ-024 o_busy SHALL be 1 in every state except IDLE.
REQ-025 CLEAR SHALL be honoured in any state: next cycle IDLE, o_load=o_SoP=0, o_wrBank=0, o_fill=0, o_timeout=0, no o_done/o_err.
REQ-026 A command other than CLEAR arriving outside IDLE, or an illegal code anywhere, SHALL pulse o_err and leave state unchanged.
REQ-027 When a change-block event and a non-CLEAR command coincide, the event SHALL be processed and the command rejected with o_err.
REQ-028 When o_done and o_err coincide, both SHALL pulse in the same cycle.
REQ-029 o_wrBank SHALL wrap 3->0; o_fill SHALL saturate at 3.

Reset
REQ-030 With i_reset=1 at a rising edge, state SHALL be IDLE and all outputs 0 the next cycle; the registered i_changeBlock SHALL be cleared to 0.
REQ-031 Reset SHALL take priority over CLEAR and all other inputs, including mid-LOAD/PROC/READ.

Configuration
REQ-032 Macro FRAME_SEQUENCER_TIMEOUT_EN, when defined, SHALL enable a watchdog: count cycles spent outside IDLE, clearing to 0 on every state change.
REQ-033 With the watchdog enabled, count reaching TIMEOUT_CYC SHALL force IDLE, drop o_load/o_SoP, pulse o_err and set o_timeout, which holds until CLEAR or reset.
REQ-034 With the macro undefined, no counter SHALL exist, o_timeout SHALL be tied 0 and non-IDLE states SHALL wait indefinitely.

Verification
REQ-035 Reset, then 3x(LOAD, i_changeBlock edge 20 cycles later) -> three o_done pulses, o_fill=3, o_wrBank=3, o_rdBase=0.
REQ-036 After REQ-035: PROC, change-block edge, i_EoP=1, then i_EoP=0 plus change-block edge -> o_SoP high until the first edge, states DRAIN->READ->IDLE, o_fill=2, one o_done.
REQ-037 PROC with o_fill=1, and READ issued in IDLE -> o_err pulse each, o_SoP stays 0, state IDLE.
REQ-038 During LOAD: issue PROC, then i_cmd=7 -> two o_err pulses, o_load stays 1; then CLEAR -> IDLE, o_wrBank=0, o_fill=0.
REQ-039 Change-block edge coinciding with a LOAD command in PROC -> DRAIN entered, o_err pulse; i_reset mid-READ -> all outputs 0 next cycle.
REQ-040 Watchdog enabled, TIMEOUT_CYC=16, PROC with no change-block -> IDLE after 16 cycles, o_err pulse, o_timeout=1 until CLEAR; with the macro undefined, still in PROC after 100 cycles.
